// File: rtl/motor_fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor_fb_pkg
//  Description : Shared definitions for the motor feedback snapshot
//                controller: Avalon word addresses, CTRL/STATUS/CMD bit
//                positions and the snapshot FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package motor_fb_pkg;

    // Avalon word addresses
    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_PERIOD     = 4'd1;
    localparam logic [3:0] ADDR_STATUS     = 4'd2;
    localparam logic [3:0] ADDR_CMD        = 4'd3;
    localparam logic [3:0] ADDR_DELTA_BASE = 4'd4;
    localparam logic [3:0] ADDR_ABS_BASE   = 4'd8;

    // CTRL bits
    localparam int CTRL_AUTO_EN_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT    = 1;

    // STATUS bits (valid/overrun are write-one-to-clear, busy is read-only)
    localparam int STATUS_VALID_BIT   = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int STATUS_BUSY_BIT    = 2;

    // CMD bits
    localparam int CMD_TRIGGER_BIT    = 0;

    // Snapshot sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DIFF    = 2'd2,
        ST_DONE    = 2'd3
    } snap_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_period_timer
//  Description : Reloadable down-counter that emits a one-cycle tick every
//                period_i clocks while enabled. A reload restarts the count
//                from period_i-1 and suppresses any tick on that cycle.
//  Ports       : clk, reset_n   - clock, async active-low reset
//                en_i           - counting enabled (auto mode, period != 0)
//                reload_i       - restart count (PERIOD or CTRL written)
//                period_i       - period value in effect after this edge
//                tick_o         - one-cycle periodic trigger
//  Revision    : 1.0  initial release
// ============================================================================
module fb_period_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic         reload_i,
    input  logic [W-1:0] period_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    // A tick fires on the cycle the count sits at zero; the same edge reloads.
    assign tick_o = en_i & ~reload_i & (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (reload_i) begin
            cnt_q <= period_i - W'(1);
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_q <= period_i - W'(1);
            end else begin
                cnt_q <= cnt_q - W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/motor_fb_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : motor_fb_snapshot_ctrl
//  Description : Captures all motor feedback words on one edge (software
//                command or periodic tick), computes per-channel deltas
//                against the previous snapshot one channel per cycle, then
//                publishes the absolute and delta banks together.
//  Ports       : clk, reset_n          - clock, async active-low reset
//                address/read/write/
//                writedata/readdata    - Avalon-MM slave, 1-cycle read latency
//                irq                   - level interrupt (irq_en & valid)
//                fb_in                 - packed feedback words, motor 0 in LSBs
//  Revision    : 1.0  initial release
// ============================================================================
module motor_fb_snapshot_ctrl
    import motor_fb_pkg::*;
#(
    parameter int N_MOTORS = 4,
    parameter int DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [3:0]                   address,
    input  logic                         read,
    input  logic                         write,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq,
    input  logic [N_MOTORS*DATA_W-1:0]   fb_in
);

    localparam int              IDX_W    = (N_MOTORS > 1) ? $clog2(N_MOTORS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MOTORS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    snap_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              auto_en_q;
    logic              irq_en_q;
    logic [31:0]       period_q;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       readdata_q;

    // The ABS bank doubles as the "previous snapshot": both are loaded with
    // the same work snapshot at the same edge and both reset to zero.
    logic [DATA_W-1:0] snap_q  [N_MOTORS];
    logic [DATA_W-1:0] dwork_q [N_MOTORS];
    logic [DATA_W-1:0] abs_q   [N_MOTORS];
    logic [DATA_W-1:0] delta_q [N_MOTORS];

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic        w_wr_ctrl, w_wr_period, w_wr_status, w_wr_cmd;
    logic        w_cmd_trig, w_tick, w_trigger, w_idle, w_drop, w_publish;
    logic [31:0] w_period_next;
    logic [31:0] w_rdata;

    assign w_wr_ctrl     = write && (address == ADDR_CTRL);
    assign w_wr_period   = write && (address == ADDR_PERIOD);
    assign w_wr_status   = write && (address == ADDR_STATUS);
    assign w_wr_cmd      = write && (address == ADDR_CMD);

    assign w_cmd_trig    = w_wr_cmd & writedata[CMD_TRIGGER_BIT];
    // A command and a tick on the same cycle merge into a single trigger.
    assign w_trigger     = w_cmd_trig | w_tick;
    assign w_idle        = (state_q == ST_IDLE);
    assign w_drop        = w_trigger & ~w_idle;
    assign w_publish     = (state_q == ST_DONE);

    // The timer reloads with the value PERIOD holds after this edge.
    assign w_period_next = w_wr_period ? writedata : period_q;

    fb_period_timer #(
        .W (32)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (auto_en_q && (period_q != '0)),
        .reload_i (w_wr_ctrl | w_wr_period),
        .period_i (w_period_next),
        .tick_o   (w_tick)
    );

    // ------------------------------------------------------------------
    // Snapshot sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_trigger) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_DIFF;
                idx_d   = '0;
            end
            ST_DIFF: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Status flags: a hardware set on the same cycle as a W1C clear wins.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d   = (valid_q & ~(w_wr_status & writedata[STATUS_VALID_BIT]))
                  | w_publish;
        overrun_d = (overrun_q & ~(w_wr_status & writedata[STATUS_OVERRUN_BIT]))
                  | (w_publish & valid_q)
                  | w_drop;
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_CTRL: begin
                w_rdata[CTRL_AUTO_EN_BIT] = auto_en_q;
                w_rdata[CTRL_IRQ_EN_BIT]  = irq_en_q;
            end
            ADDR_PERIOD: begin
                w_rdata = period_q;
            end
            ADDR_STATUS: begin
                w_rdata[STATUS_VALID_BIT]   = valid_q;
                w_rdata[STATUS_OVERRUN_BIT] = overrun_q;
                w_rdata[STATUS_BUSY_BIT]    = ~w_idle;
            end
            default: begin
            end
        endcase
        for (int i = 0; i < N_MOTORS; i++) begin
            if (address == (ADDR_DELTA_BASE + 4'(i))) begin
                w_rdata = 32'(delta_q[i]);
            end
            if (address == (ADDR_ABS_BASE + 4'(i))) begin
                w_rdata = 32'(abs_q[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_en_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            if (w_wr_ctrl) begin
                auto_en_q <= writedata[CTRL_AUTO_EN_BIT];
                irq_en_q  <= writedata[CTRL_IRQ_EN_BIT];
            end
            if (w_wr_period) begin
                period_q <= writedata;
            end
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            if (read) begin
                readdata_q <= w_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot datapath: capture, per-channel delta, atomic publication
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_MOTORS; i++) begin
                snap_q[i]  <= '0;
                dwork_q[i] <= '0;
                abs_q[i]   <= '0;
                delta_q[i] <= '0;
            end
        end else begin
            if (state_q == ST_CAPTURE) begin
                for (int i = 0; i < N_MOTORS; i++) begin
                    snap_q[i] <= fb_in[i*DATA_W +: DATA_W];
                end
            end
            // Modulo subtraction: wrap-around is the correct delta for
            // both signed and unsigned encoder counts.
            if (state_q == ST_DIFF) begin
                dwork_q[idx_q] <= snap_q[idx_q] - abs_q[idx_q];
            end
            if (w_publish) begin
                for (int i = 0; i < N_MOTORS; i++) begin
                    abs_q[i]   <= snap_q[i];
                    delta_q[i] <= dwork_q[i];
                end
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_en_q & valid_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_fb_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_fb_snapshot_ctrl
//  Description : Directed bench for motor_fb_snapshot_ctrl. A register-level
//                model predicts readdata and irq every cycle; literal
//                expectations pin latency, wrap-around deltas, overrun and
//                the reset-abort behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_motor_fb_snapshot_ctrl;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b1;
    logic [3:0]        address   = '0;
    logic              read      = 1'b0;
    logic              write     = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [N*DW-1:0]   fb_in     = '0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    motor_fb_snapshot_ctrl #(
        .N_MOTORS (N),
        .DATA_W   (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .fb_in     (fb_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: busy is a countdown of remaining cycles, the timer
    // is "ticks every PERIOD cycles since the last reload".
    // ------------------------------------------------------------------
    logic        m_auto = 0, m_irqen = 0, m_valid = 0, m_ovr = 0;
    logic [31:0] m_period = 0, m_rd = 0;
    logic [31:0] m_abs [N];
    logic [31:0] m_delta [N];
    logic [31:0] m_snap [N];
    int          m_left = 0, m_elapsed = 0;

    function automatic logic [31:0] m_reg(input logic [3:0] a);
        if (a == 4'd0) return {30'b0, m_irqen, m_auto};
        if (a == 4'd1) return m_period;
        if (a == 4'd2) return {29'b0, (m_left > 0), m_ovr, m_valid};
        if (a >= 4'd4 && int'(a) < 4 + N) return m_delta[a - 4'd4];
        if (a >= 4'd8 && int'(a) < 8 + N) return m_abs[a - 4'd8];
        return 32'd0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic was_busy, wr_ctrl, wr_per, wr_stat, cmd, tick, trig, pub;
        if (!reset_n) begin
            m_auto = 0; m_irqen = 0; m_valid = 0; m_ovr = 0;
            m_period = 0; m_rd = 0; m_left = 0; m_elapsed = 0;
            for (int i = 0; i < N; i++) begin
                m_abs[i] = 0; m_delta[i] = 0; m_snap[i] = 0;
            end
        end else begin
            was_busy = (m_left > 0);
            if (read) m_rd = m_reg(address);
            wr_ctrl = write && address == 4'd0;
            wr_per  = write && address == 4'd1;
            wr_stat = write && address == 4'd2;
            cmd     = write && address == 4'd3 && writedata[0];
            tick    = m_auto && (m_period != 0) && !(wr_ctrl || wr_per)
                      && ((m_elapsed % int'(m_period)) == int'(m_period) - 1);
            trig    = cmd || tick;
            pub     = (m_left == 1);
            if (m_left == N + 2)
                for (int i = 0; i < N; i++) m_snap[i] = fb_in[i*DW +: DW];
            if (pub)
                for (int i = 0; i < N; i++) begin
                    m_delta[i] = m_snap[i] - m_abs[i];
                    m_abs[i]   = m_snap[i];
                end
            m_ovr   = (m_ovr & ~(wr_stat & writedata[1])) | (pub & m_valid) | (trig & was_busy);
            m_valid = (m_valid & ~(wr_stat & writedata[0])) | pub;
            if (m_left > 0) m_left--;
            if (trig && !was_busy) m_left = N + 2;
            if (wr_ctrl || wr_per) m_elapsed = 0;
            else if (m_auto && m_period != 0) m_elapsed++;
            if (wr_ctrl) begin m_auto = writedata[0]; m_irqen = writedata[1]; end
            if (wr_per) m_period = writedata;
        end
    end

    // Single compare process: outputs are registered, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_readdata", readdata, m_rd);
                check("model_irq", {31'b0, irq}, {31'b0, m_irqen & m_valid});
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus helpers (called on a falling edge, return on a falling edge)
    // ------------------------------------------------------------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic set_fb(input logic [31:0] f0, f1, f2, f3);
        fb_in = {f3, f2, f1, f0};
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!irq && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] exp_d [N];
        int          n;

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Reset state
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            check("reset_read", v, 32'd0);
        end
        check("reset_irq", {31'b0, irq}, 32'd0);

        // First snapshot: DELTA equals ABS, published 6 edges after CMD
        wr(4'd0, 32'h2);
        set_fb(32'd10, 32'd20, 32'd30, 32'd40);
        wr(4'd3, 32'h1);
        wait_irq(n);
        check("first_latency", 32'(n), 32'd6);
        for (int i = 0; i < N; i++) begin
            rd(4'(4 + i), v); check("first_delta", v, 32'(10 * (i + 1)));
            rd(4'(8 + i), v); check("first_abs",   v, 32'(10 * (i + 1)));
        end
        rd(4'd2, v); check("first_status", v, 32'h1);

        // Second snapshot: modulo wrap on decreasing counts
        wr(4'd2, 32'h1);
        set_fb(32'd15, 32'd18, 32'hFFFF_FFF0, 32'd40);
        wr(4'd3, 32'h1);
        repeat (8) @(negedge clk);
        exp_d = '{32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFD2, 32'd0};
        for (int i = 0; i < N; i++) begin
            rd(4'(4 + i), v); check("wrap_delta", v, exp_d[i]);
        end

        // CMD while busy is dropped and flags overrun
        wr(4'd2, 32'h3);
        wr(4'd3, 32'h1);
        wr(4'd3, 32'h1);
        repeat (8) @(negedge clk);
        rd(4'd2, v); check("busy_overrun_status", v, 32'h3);

        // Poll DELTA[0] each cycle: old value until publication, then new
        wr(4'd2, 32'h3);
        set_fb(32'd115, 32'd18, 32'hFFFF_FFF0, 32'd40);
        wr(4'd3, 32'h1);
        for (int k = 0; k < 8; k++) begin
            rd(4'd4, v);
            check("poll_delta0", v, (k < 6) ? 32'd0 : 32'd100);
        end

        // Periodic mode: two snapshots 100 cycles apart, second overruns
        wr(4'd2, 32'h3);
        wr(4'd1, 32'd100);
        wr(4'd0, 32'h3);
        repeat (215) @(negedge clk);
        rd(4'd2, v); check("auto_status", v, 32'h3);
        check("auto_irq", {31'b0, irq}, 32'd1);
        wr(4'd2, 32'h3);
        check("w1c_irq", {31'b0, irq}, 32'd0);

        // CMD coincident with a tick: one snapshot, no overrun
        wr(4'd0, 32'h0);
        wr(4'd0, 32'h3);
        repeat (99) @(negedge clk);
        wr(4'd3, 32'h1);
        repeat (10) @(negedge clk);
        rd(4'd2, v); check("coincident_status", v, 32'h1);
        wr(4'd0, 32'h2);

        // Reset during DIFF aborts without publication
        wr(4'd3, 32'h1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_readdata", readdata, 32'd0);
        check("abort_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(4'd2, v); check("abort_status", v, 32'd0);
        rd(4'd8, v); check("abort_abs0", v, 32'd0);
        set_fb(32'd7, 32'd8, 32'd9, 32'd10);
        wr(4'd0, 32'h2);
        wr(4'd3, 32'h1);
        wait_irq(n);
        check("post_reset_latency", 32'(n), 32'd6);
        for (int i = 0; i < N; i++) begin
            rd(4'(4 + i), v); check("post_reset_delta", v, 32'(7 + i));
            rd(4'(8 + i), v); check("post_reset_abs",   v, 32'(7 + i));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
